// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - fetch-stage bus: hazard controls, redirects, imem port and IF/ID outputs
interface instruction_fetch_unit_if;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic [31:0] pc;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  modport master (
    input  stall, flush, branch_taken, branch_target, jump, jump_target, imem_instruction,
    output imem_address, pc, if_id_instruction, if_id_pc_plus4, if_id_valid, fetch_fault,
           fetch_count
  );

  modport slave (
    output stall, flush, branch_taken, branch_target, jump, jump_target, imem_instruction,
    input  imem_address, pc, if_id_instruction, if_id_pc_plus4, if_id_valid, fetch_fault,
           fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: program counter, IF/ID register and retired-fetch counter
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 174
) (
  input logic                      clk,
  input logic                      rst,
  instruction_fetch_unit_if.master bus
);
  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] branch_pc;
  logic [31:0] jump_pc;
  logic        redirect;
  logic        fault;
  logic [31:0] ins_q;
  logic [31:0] p4_q;
  logic        valid_q;
  logic        fault_q;
  logic [31:0] count_q;

  assign pc_plus4  = pc_q + 32'd4;
  assign branch_pc = bus.branch_target & ~32'h3;
  assign jump_pc   = bus.jump_target & ~32'h3;
  assign redirect  = bus.branch_taken | bus.jump;
  assign fault     = {2'b00, pc_q[31:2]} >= IMEM_LIMIT;

  // Branch outranks jump: it belongs to the older instruction in the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (bus.branch_taken) begin
      pc_q <= branch_pc;
    end else if (bus.jump) begin
      pc_q <= jump_pc;
    end else if (!bus.stall) begin
      pc_q <= pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ins_q   <= 32'h0;
      p4_q    <= 32'h0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      count_q <= 32'h0;
    end else if (bus.flush || redirect) begin
      ins_q   <= 32'h0;
      p4_q    <= 32'h0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (!bus.stall) begin
      if (fault) begin
        ins_q   <= 32'h0;
        p4_q    <= pc_plus4;
        valid_q <= 1'b0;
        fault_q <= 1'b1;
      end else begin
        ins_q   <= bus.imem_instruction;
        p4_q    <= pc_plus4;
        valid_q <= 1'b1;
        fault_q <= 1'b0;
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign bus.pc                = pc_q;
  assign bus.imem_address      = {pc_q[31:2], 2'b00};
  assign bus.if_id_instruction = ins_q;
  assign bus.if_id_pc_plus4    = p4_q;
  assign bus.if_id_valid       = valid_q;
  assign bus.fetch_fault       = fault_q;
  assign bus.fetch_count       = count_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed and randomized checks of the fetch stage against a reference model
module tb_instruction_fetch_unit;
  logic clk;
  logic rst;
  logic [31:0] mem [0:1023];
  int errors;
  int checks;

  logic [31:0] m_pc, m_ins, m_p4, m_cnt;
  logic        m_valid, m_fault;
  logic [31:0] saved_cnt;

  instruction_fetch_unit_if ifc ();

  instruction_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(174)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  assign ifc.imem_instruction = mem[ifc.imem_address[11:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    check("pc", ifc.pc, m_pc);
    check("imem_address", ifc.imem_address, (m_pc / 4) * 4);
    check("if_id_instruction", ifc.if_id_instruction, m_ins);
    check("if_id_pc_plus4", ifc.if_id_pc_plus4, m_p4);
    check("if_id_valid", {31'h0, ifc.if_id_valid}, {31'h0, m_valid});
    check("fetch_fault", {31'h0, ifc.fetch_fault}, {31'h0, m_fault});
    check("fetch_count", ifc.fetch_count, m_cnt);
  endtask

  task automatic reset_model();
    m_pc = 32'h0; m_ins = 32'h0; m_p4 = 32'h0; m_cnt = 32'h0;
    m_valid = 1'b0; m_fault = 1'b0;
  endtask

  task automatic clear_inputs();
    ifc.stall = 1'b0; ifc.flush = 1'b0;
    ifc.branch_taken = 1'b0; ifc.branch_target = 32'h0;
    ifc.jump = 1'b0; ifc.jump_target = 32'h0;
  endtask

  // Predict the next state from the fetch rules, advance one edge, compare everything.
  task automatic step();
    logic [31:0] n_pc, n_ins, n_p4, n_cnt, widx;
    logic        n_v, n_f;
    n_pc = m_pc; n_ins = m_ins; n_p4 = m_p4; n_cnt = m_cnt; n_v = m_valid; n_f = m_fault;
    widx = m_pc / 4;
    if (ifc.branch_taken)   n_pc = (ifc.branch_target / 4) * 4;
    else if (ifc.jump)      n_pc = (ifc.jump_target / 4) * 4;
    else if (!ifc.stall)    n_pc = m_pc + 4;
    if (ifc.flush || ifc.branch_taken || ifc.jump) begin
      n_ins = 0; n_p4 = 0; n_v = 0; n_f = 0;
    end else if (!ifc.stall) begin
      if (widx >= 174) begin
        n_ins = 0; n_p4 = m_pc + 4; n_v = 0; n_f = 1;
      end else begin
        n_ins = mem[widx % 1024]; n_p4 = m_pc + 4; n_v = 1; n_f = 0; n_cnt = m_cnt + 1;
      end
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_ins = n_ins; m_p4 = n_p4; m_cnt = n_cnt; m_valid = n_v; m_fault = n_f;
    compare_all();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020;
    mem[3] = 32'h0000_0000;
    clear_inputs();
    reset_model();
    rst = 1'b1;
    #3;
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    step();
    check("seq_ins0", ifc.if_id_instruction, 32'h2008_0001);
    step();
    check("seq_pc8", ifc.pc, 32'h8);
    check("seq_p4_8", ifc.if_id_pc_plus4, 32'h8);

    ifc.stall = 1'b1;
    step();
    step();
    check("stall_pc", ifc.pc, 32'h8);
    check("stall_ins", ifc.if_id_instruction, 32'h2009_0002);
    check("stall_cnt", ifc.fetch_count, 32'd2);
    ifc.stall = 1'b0;
    step();
    check("release_pc", ifc.pc, 32'hC);
    check("release_ins", ifc.if_id_instruction, 32'h0109_5020);
    check("release_cnt", ifc.fetch_count, 32'd3);
    step();

    ifc.branch_taken = 1'b1; ifc.branch_target = 32'h40;
    ifc.jump = 1'b1; ifc.jump_target = 32'h80; ifc.stall = 1'b1;
    step();
    check("bj_pc", ifc.pc, 32'h40);
    check("bj_valid", {31'h0, ifc.if_id_valid}, 32'h0);
    clear_inputs();
    step();
    check("bj_ins", ifc.if_id_instruction, mem[16]);
    check("bj_p4", ifc.if_id_pc_plus4, 32'h44);

    ifc.jump = 1'b1; ifc.jump_target = 32'h22;
    step();
    check("misalign_pc", ifc.pc, 32'h20);
    check("misalign_addr", ifc.imem_address, 32'h20);
    clear_inputs();

    ifc.flush = 1'b1; ifc.stall = 1'b1;
    step();
    check("flushstall_pc", ifc.pc, 32'h20);
    clear_inputs();
    step();
    check("refetch_ins", ifc.if_id_instruction, mem[8]);

    ifc.jump = 1'b1; ifc.jump_target = 32'h2B8;
    step();
    clear_inputs();
    saved_cnt = ifc.fetch_count;
    step();
    check("fault_flag", {31'h0, ifc.fetch_fault}, 32'h1);
    check("fault_p4", ifc.if_id_pc_plus4, 32'h2BC);
    check("fault_pc", ifc.pc, 32'h2BC);
    check("fault_cnt", ifc.fetch_count, saved_cnt);

    ifc.jump = 1'b1; ifc.jump_target = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    step();
    check("wrap_pc", ifc.pc, 32'h0);

    ifc.jump = 1'b1; ifc.jump_target = 32'h30;
    step();
    clear_inputs();
    ifc.flush = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    reset_model();
    compare_all();
    #2;
    rst = 1'b0;
    ifc.flush = 1'b0;

    for (int n = 0; n < 400; n++) begin
      ifc.stall = ($urandom_range(0, 3) == 0);
      ifc.flush = ($urandom_range(0, 9) == 0);
      ifc.branch_taken = ($urandom_range(0, 9) == 0);
      ifc.jump = ($urandom_range(0, 9) == 0);
      ifc.branch_target = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 32'h3FF));
      ifc.jump_target = 32'($urandom_range(0, 32'h3FF));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage of the pipelined core; sits directly upstream of the combinational instruction memory and feeds the decode stage.
- Holds the program counter and drives the word-aligned fetch address to instruction memory.
- Captures the returned instruction word into the IF/ID pipeline register, applying stall, flush and branch/jump redirect, and keeps a retired-fetch counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 174, number of valid 32-bit words in instruction memory; fetches at or beyond this index are faults.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous reset, active-high.
- Stall  input  1  hazard-unit stall; hold PC and IF/ID.
- Flush  input  1  squash the IF/ID contents.
- BranchTaken  input  1  redirect to BranchTarget this cycle.
- BranchTarget  input  32  branch destination byte address.
- Jump  input  1  redirect to JumpTarget this cycle.
- JumpTarget  input  32  jump destination byte address.
- IMemAddress  output  32  byte address to instruction memory (equals PC).
- IMemInstruction  input  32  instruction word returned combinationally for IMemAddress.
- PC  output  32  current program counter.
- IF_ID_Instruction  output  32  registered instruction to decode.
- IF_ID_PCPlus4  output  32  registered PC+4 of that instruction.
- IF_ID_Valid  output  1  registered instruction is real (not a bubble).
- FetchFault  output  1  registered; IF/ID slot came from an out-of-range fetch.
- FetchCount  output  32  number of valid instructions loaded into IF/ID.

Behaviour:
- Reset (async, Rst=1): PC=RESET_PC; IF_ID_Instruction=0 (NOP); IF_ID_PCPlus4=0; IF_ID_Valid=0; FetchFault=0; FetchCount=0. All registers are held while Rst is high.
- IMemAddress=PC with bits [1:0] forced to 00. Combinational, zero latency. Instruction memory indexes by IMemAddress[11:2].
- Fault detection (combinational): fault = (PC[31:2] >= IMEM_WORDS).
- PC update on each rising edge, in priority order:
  - BranchTaken: PC <= {BranchTarget[31:2],2'b00}. Wins over Jump when both are asserted; the branch is the older instruction.
  - Jump: PC <= {JumpTarget[31:2],2'b00}.
  - Stall: PC holds.
  - Otherwise: PC <= PC+4, 32-bit wrap (32'hFFFF_FFFC -> 0).
  - A redirect overrides Stall. A redirect is never lost.
- IF/ID update on each rising edge, in priority order:
  - Flush, BranchTaken or Jump: Instruction=0, PCPlus4=0, Valid=0, FetchFault=0.
  - Stall: all IF/ID fields hold.
  - Fault: Instruction=0, PCPlus4=PC+4, Valid=0, FetchFault=1. The PC still advances normally.
  - Otherwise: Instruction=IMemInstruction, PCPlus4=PC+4, Valid=1, FetchFault=0.
- FetchCount: increments by 1 on each edge where IF/ID loads with Valid=1. Wraps at 2^32. Holds otherwise.
- Latency: one cycle from PC to IF_ID_Instruction. A redirect's first target instruction appears in IF/ID two edges after the redirect cycle, with one bubble in between.
- Flush with Stall: IF/ID is squashed and PC holds. The instruction at PC is refetched next cycle.
- Rst asserted mid-operation: immediate asynchronous return to reset values, regardless of any pending redirect or stall.

Test Plan:
- Reset/sequential fetch:
  - Stimulus: Rst high then low; memory words 0..3 = 0x20080001, 0x20090002, 0x01095020, 0x00000000.
  - Required: PC goes 0,4,8,12. IF_ID_Instruction follows one cycle later (0x20080001, 0x20090002, ...) with PCPlus4 = 4, 8, 12. Valid=1; FetchCount = 3 after three loads.
- Stall:
  - Stimulus: Stall=1 for 2 cycles while PC=8.
  - Required: PC stays 8. IF_ID holds 0x20090002 / PCPlus4=8 / Valid=1. FetchCount is unchanged. After release, PC=12 and IF/ID=0x01095020.
- Branch vs jump:
  - Stimulus: at PC=16, BranchTaken=1, BranchTarget=0x40, Jump=1, JumpTarget=0x80, Stall=1.
  - Required: next PC=0x40. IF_ID_Valid=0 and Instruction=0. The following edge loads word 16 with PCPlus4=0x44.
- Misaligned target:
  - Stimulus: Jump=1, JumpTarget=0x0000_0022.
  - Required: PC=0x20, IMemAddress=0x20.
- Fault:
  - Stimulus: Jump to 0x2B8 (index 174).
  - Required: next edge gives FetchFault=1, Valid=0, Instruction=0, PCPlus4=0x2BC. PC advances to 0x2BC. FetchCount is unchanged.
- Async reset mid-run:
  - Stimulus: assert Rst between clock edges at PC=0x30 with Flush=1.
  - Required: PC=RESET_PC, all IF/ID fields=0 and FetchCount=0 immediately, without waiting for a clock edge.
